// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared FP status type and constants
package fpnew_pkg;

  localparam int unsigned NUM_STATUS_BITS = 5;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_reorder_wr_arb.sv
// rtl/fpnew_reorder_wr_arb.sv - per-slot result write select, lowest group wins
module fpnew_reorder_wr_arb #(
  parameter  int unsigned NumOpGroups   = 4,
  parameter  int unsigned Depth         = 8,
  localparam int unsigned IdWidth       = $clog2(Depth),
  localparam int unsigned GroupIdxWidth = (NumOpGroups > 1) ? $clog2(NumOpGroups) : 1
) (
  input  logic [NumOpGroups-1:0]                    valid_i,
  input  logic [NumOpGroups-1:0][IdWidth-1:0]       id_i,
  input  logic [Depth-1:0]                          alloc_i,
  input  logic [Depth-1:0]                          done_i,
  output logic [Depth-1:0]                          wr_en_o,
  output logic [Depth-1:0][GroupIdxWidth-1:0]       wr_sel_o,
  output logic                                      illegal_o
);

  // Groups are scanned in ascending order, so a slot already claimed earlier
  // in the loop turns every later request for it into an illegal write.
  always_comb begin
    wr_en_o   = '0;
    wr_sel_o  = '0;
    illegal_o = 1'b0;
    for (int g = 0; g < int'(NumOpGroups); g++) begin
      if (valid_i[g]) begin
        if (alloc_i[id_i[g]] && !done_i[id_i[g]] && !wr_en_o[id_i[g]]) begin
          wr_en_o[id_i[g]]  = 1'b1;
          wr_sel_o[id_i[g]] = GroupIdxWidth'(g);
        end else begin
          illegal_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpnew_result_reorder.sv
// rtl/fpnew_result_reorder.sv - in-order retirement buffer for out-of-order opgroup results
module fpnew_result_reorder
  import fpnew_pkg::*;
#(
  parameter  int unsigned Width       = 64,
  parameter  int unsigned NumOpGroups = 4,
  parameter  int unsigned Depth       = 8,
  parameter  int unsigned TagWidth    = 5,
  localparam int unsigned IdWidth     = $clog2(Depth)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         alloc_valid_i,
  output logic                                         alloc_ready_o,
  input  logic [TagWidth-1:0]                          alloc_tag_i,
  output logic [IdWidth-1:0]                           alloc_id_o,
  input  logic [NumOpGroups-1:0]                       res_valid_i,
  output logic [NumOpGroups-1:0]                       res_ready_o,
  input  logic [NumOpGroups-1:0][IdWidth-1:0]          res_id_i,
  input  logic [NumOpGroups-1:0][Width-1:0]            res_result_i,
  input  logic [NumOpGroups-1:0][NUM_STATUS_BITS-1:0]  res_status_i,
  input  logic [NumOpGroups-1:0]                       res_ext_bit_i,
  output logic                                         commit_valid_o,
  input  logic                                         commit_ready_i,
  output logic [Width-1:0]                             commit_result_o,
  output logic [NUM_STATUS_BITS-1:0]                   commit_status_o,
  output logic                                         commit_ext_bit_o,
  output logic [TagWidth-1:0]                          commit_tag_o,
  output logic [NUM_STATUS_BITS-1:0]                   fflags_o,
  input  logic                                         fflags_clr_i,
  output logic                                         err_o,
  output logic [IdWidth:0]                             count_o,
  output logic                                         busy_o
);

  localparam int unsigned GroupIdxWidth = (NumOpGroups > 1) ? $clog2(NumOpGroups) : 1;

  typedef struct packed {
    logic                alloc;
    logic                done;
    logic [Width-1:0]    result;
    status_t             status;
    logic                ext_bit;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t                        slot_q [Depth];
  logic [IdWidth-1:0]            head_q, tail_q;
  logic [IdWidth:0]              count_q;
  logic [NUM_STATUS_BITS-1:0]    fflags_q;
  logic                          err_q;

  logic [Depth-1:0]                    slot_alloc, slot_done;
  logic [Depth-1:0]                    wr_en;
  logic [Depth-1:0][GroupIdxWidth-1:0] wr_sel;
  logic                                wr_illegal;
  logic                                alloc_fire, commit_fire;

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      slot_alloc[i] = slot_q[i].alloc;
      slot_done[i]  = slot_q[i].done;
    end
  end

  // Readiness looks only at the registered count, so a slot freed by a
  // same-cycle commit cannot be re-allocated until the next cycle.
  assign alloc_ready_o = (count_q != (IdWidth+1)'(Depth)) & ~flush_i;
  assign alloc_id_o    = tail_q;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  assign res_ready_o   = {NumOpGroups{~flush_i}};

  assign commit_valid_o   = slot_q[head_q].alloc & slot_q[head_q].done;
  assign commit_result_o  = slot_q[head_q].result;
  assign commit_status_o  = slot_q[head_q].status;
  assign commit_ext_bit_o = slot_q[head_q].ext_bit;
  assign commit_tag_o     = slot_q[head_q].tag;
  assign commit_fire      = commit_valid_o & commit_ready_i;

  assign fflags_o = fflags_q;
  assign err_o    = err_q;
  assign count_o  = count_q;
  assign busy_o   = (count_q != '0);

  fpnew_reorder_wr_arb #(
    .NumOpGroups (NumOpGroups),
    .Depth       (Depth)
  ) i_wr_arb (
    .valid_i   (res_valid_i & res_ready_o),
    .id_i      (res_id_i),
    .alloc_i   (slot_alloc),
    .done_i    (slot_done),
    .wr_en_o   (wr_en),
    .wr_sel_o  (wr_sel),
    .illegal_o (wr_illegal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        slot_q[i].alloc <= 1'b0;
        slot_q[i].done  <= 1'b0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= wr_illegal;

      for (int i = 0; i < int'(Depth); i++) begin
        if (wr_en[i]) begin
          slot_q[i].done    <= 1'b1;
          slot_q[i].result  <= res_result_i[wr_sel[i]];
          slot_q[i].status  <= status_t'(res_status_i[wr_sel[i]]);
          slot_q[i].ext_bit <= res_ext_bit_i[wr_sel[i]];
        end
      end

      if (commit_fire) begin
        slot_q[head_q].alloc <= 1'b0;
        slot_q[head_q].done  <= 1'b0;
        head_q               <= head_q + 1'b1;
      end

      if (alloc_fire) begin
        slot_q[tail_q].alloc <= 1'b1;
        slot_q[tail_q].done  <= 1'b0;
        slot_q[tail_q].tag   <= alloc_tag_i;
        tail_q               <= tail_q + 1'b1;
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Clear takes effect first, so a same-cycle commit leaves only its own flags.
      if (fflags_clr_i) begin
        fflags_q <= commit_fire ? commit_status_o : '0;
      end else if (commit_fire) begin
        fflags_q <= fflags_q | commit_status_o;
      end

      // Flush overrides every pointer and slot update above but keeps fflags.
      if (flush_i) begin
        for (int i = 0; i < int'(Depth); i++) begin
          slot_q[i].alloc <= 1'b0;
          slot_q[i].done  <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end
    end
  end

endmodule
